// File: rtl/gf_inv_4_pipe_if.sv
// Valid/ready handshake bundle for gf_inv_4_pipe: an input channel carrying the
// element and tag to invert, and an output channel returning the inverse and tag.
interface gf_inv_4_pipe_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid,
        output in_data,
        output in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_tag
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_tag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_tag
    );
endinterface

// File: rtl/gf_inv_4_pipe.sv
// Two-stage pipelined GF(2^4) inverter (tower field over GF(2^2), normal bases).
// Optional self-check of each result is enabled by defining GF_INV_4_CHECK_EN.
module gf_inv_4_pipe #(
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef GF_INV_4_CHECK_EN
    output logic err,
`endif
    gf_inv_4_pipe_if.slave bus
);

    // GF(2^2) helpers, normal basis [Omega^2, Omega]
    function automatic logic [1:0] gf2_mul(input logic [1:0] x, input logic [1:0] y);
        logic e;
        e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
    endfunction

    function automatic logic [1:0] gf2_sq(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    function automatic logic [1:0] gf2_sclw(input logic [1:0] x);
        return {x[1] ^ x[0], x[1]};
    endfunction

`ifdef GF_INV_4_CHECK_EN
    function automatic logic [3:0] gf4_mul(input logic [3:0] x, input logic [3:0] y);
        logic [1:0] e;
        e = gf2_sclw(gf2_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
        return {gf2_mul(x[3:2], y[3:2]) ^ e, gf2_mul(x[1:0], y[1:0]) ^ e};
    endfunction
`endif

    logic             w_s2_take;
    logic             w_s1_take;
    logic [1:0]       w_in_a;
    logic [1:0]       w_in_b;
    logic [1:0]       w_in_c;
    logic [1:0]       w_d;
    logic [3:0]       w_inv;

    logic             r_s1_valid;
    logic [1:0]       r_s1_a;
    logic [1:0]       r_s1_b;
    logic [1:0]       r_s1_c;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic [3:0]       r_s2_data;
    logic [TAG_W-1:0] r_s2_tag;

    // A stage advances when its downstream slot is empty or being drained.
    assign w_s2_take = !r_s2_valid || bus.out_ready;
    assign w_s1_take = !r_s1_valid || w_s2_take;

    assign w_in_a = bus.in_data[3:2];
    assign w_in_b = bus.in_data[1:0];
    assign w_in_c = gf2_sclw(gf2_sq(w_in_a ^ w_in_b)) ^ gf2_mul(w_in_a, w_in_b);

    assign w_d   = gf2_sq(r_s1_c);
    assign w_inv = {gf2_mul(w_d, r_s1_b), gf2_mul(w_d, r_s1_a)};

    assign bus.in_ready  = w_s1_take;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_s2_data;
    assign bus.out_tag   = r_s2_tag;

    // Stage 1: capture the element halves and the GF(2^2) norm term c.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= 2'b00;
            r_s1_b     <= 2'b00;
            r_s1_c     <= 2'b00;
            r_s1_tag   <= '0;
        end else if (w_s1_take) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_a   <= w_in_a;
                r_s1_b   <= w_in_b;
                r_s1_c   <= w_in_c;
                r_s1_tag <= bus.in_tag;
            end else begin
                r_s1_a   <= r_s1_a;
                r_s1_b   <= r_s1_b;
                r_s1_c   <= r_s1_c;
                r_s1_tag <= r_s1_tag;
            end
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Stage 2: invert c and scale both halves to form the output element.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= 4'h0;
            r_s2_tag   <= '0;
        end else if (w_s2_take) begin
            r_s2_valid <= r_s1_valid;
            r_s2_data  <= w_inv;
            r_s2_tag   <= r_s1_tag;
        end else begin
            r_s2_valid <= r_s2_valid;
            r_s2_data  <= r_s2_data;
            r_s2_tag   <= r_s2_tag;
        end
    end

`ifdef GF_INV_4_CHECK_EN
    logic [3:0] r_s2_elem;
    logic       r_err;
    logic       w_bad;

    // The source element follows its result so the product can be checked at drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_elem <= 4'h0;
        end else if (w_s2_take) begin
            r_s2_elem <= {r_s1_a, r_s1_b};
        end else begin
            r_s2_elem <= r_s2_elem;
        end
    end

    assign w_bad = (r_s2_elem == 4'h0) ? (r_s2_data != 4'h0)
                                       : (gf4_mul(r_s2_elem, r_s2_data) != 4'hF);

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_s2_valid && bus.out_ready && w_bad) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_gf_inv_4_pipe.sv
// Self-checking bench for gf_inv_4_pipe: directed cases plus randomized
// valid/ready traffic scored against a polynomial-basis GF(16) reference.
module tb_gf_inv_4_pipe;
    localparam int TAG_W = 4;

    typedef struct packed {
        logic [3:0]       din;
        logic [TAG_W-1:0] tag;
        logic [3:0]       exp;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gf_inv_4_pipe_if #(.TAG_W(TAG_W)) bus ();
`ifdef GF_INV_4_CHECK_EN
    logic err;
`endif

    gf_inv_4_pipe #(.TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
`ifdef GF_INV_4_CHECK_EN
        .err (err),
`endif
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_pops   = 0;
    ent_t       sb[$];
    logic [3:0] next_exp;
    bit         acc;
    bit         hold_prev;
    logic [3:0] prev_data;
    logic [3:0] prev_tag;
    logic [3:0] outs_by_tag [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // GF(4): 2'b11 = 1, 2'b01 = W, 2'b10 = W^2; multiply through discrete logs.
    function automatic int lg(input logic [1:0] x);
        case (x)
            2'b11:   return 0;
            2'b01:   return 1;
            default: return 2;
        endcase
    endfunction

    function automatic logic [1:0] m_mul2(input logic [1:0] x, input logic [1:0] y);
        if (x == 2'b00 || y == 2'b00) return 2'b00;
        case ((lg(x) + lg(y)) % 3)
            0:       return 2'b11;
            1:       return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    // {a,b} = a*Z^4 + b*Z = a + (a+b)Z in basis {1,Z}, with Z^2 = Z + W.
    function automatic logic [3:0] m_mul4(input logic [3:0] x, input logic [3:0] y);
        logic [1:0] p0, p1, q0, q1, r0, r1;
        p0 = x[3:2]; p1 = x[3:2] ^ x[1:0];
        q0 = y[3:2]; q1 = y[3:2] ^ y[1:0];
        r0 = m_mul2(p0, q0) ^ m_mul2(m_mul2(p1, q1), 2'b01);
        r1 = m_mul2(p0, q1) ^ m_mul2(p1, q0) ^ m_mul2(p1, q1);
        return {r0, r0 ^ r1};
    endfunction

    function automatic logic [3:0] ref_inv(input logic [3:0] x);
        logic [3:0] y;
        if (x == 4'h0) return 4'h0;
        for (int i = 1; i < 16; i++) begin
            y = 4'(i);
            if (m_mul4(x, y) == 4'hF) return y;
        end
        return 4'h0;
    endfunction

    task automatic drive(input logic [3:0] d, input logic [3:0] t, input logic [3:0] e);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_tag   = t;
        next_exp     = e;
    endtask

    // One clock: score handshakes at the falling edge, then step past the rising edge.
    task automatic tick();
        ent_t e;
        @(negedge clk);
        acc = 1'b0;
        if (rst) begin
            sb.delete();
            hold_prev = 1'b0;
        end else begin
            check("in_ready", 32'((sb.size() < 2) || bus.out_ready), 32'(bus.in_ready));
            if (hold_prev) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", 32'(bus.out_data), 32'(prev_data));
                check("hold_tag", 32'(bus.out_tag), 32'(prev_tag));
            end
            if (bus.out_valid && bus.out_ready) begin
                check("pop_avail", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_pops++;
                    outs_by_tag[bus.out_tag] = bus.out_data;
                    check("data", 32'(bus.out_data), 32'(e.exp));
                    check("tag", 32'(bus.out_tag), 32'(e.tag));
                    if (e.din == 4'h0)
                        check("zero_prod", 32'(bus.out_data), 32'h0);
                    else
                        check("prod", 32'(m_mul4(e.din, bus.out_data)), 32'hF);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{din: bus.in_data, tag: bus.in_tag, exp: next_exp});
                acc = 1'b1;
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
            prev_tag  = bus.out_tag;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] kin  [4];
        logic [3:0] kout [4];
        logic [3:0] bp   [4];
        int sent, cyc, pops0;

        kin  = '{4'h0, 4'hF, 4'h6, 4'hE};
        kout = '{4'h0, 4'hF, 4'hE, 4'h6};
        bp   = '{4'h3, 4'h7, 4'h9, 4'hB};
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 4'h0; bus.in_tag = 4'h0;
        bus.out_ready = 1'b0;
        next_exp = 4'h0; hold_prev = 1'b0;
        @(posedge clk); #1;
        tick();
        rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'h0);
        check("rst_out_tag", 32'(bus.out_tag), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef GF_INV_4_CHECK_EN
        check("rst_err", 32'(err), 32'd0);
`endif

        // Single transfer, 2-cycle latency
        bus.out_ready = 1'b1;
        drive(4'hC, 4'd1, 4'h2);
        tick();
        bus.in_valid = 1'b0;
        check("lat1_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("lat2_valid", 32'(bus.out_valid), 32'd1);
        check("lat2_data", 32'(bus.out_data), 32'h2);
        check("lat2_tag", 32'(bus.out_tag), 32'd1);
        tick();
        check("single_drain", 32'(sb.size()), 32'd0);

        // Known inverses back to back
        pops0 = n_pops;
        for (int i = 0; i < 4; i++) begin
            drive(kin[i], 4'(i + 2), kout[i]);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("known_drain", 32'(n_pops - pops0), 32'd4);

        // Exhaustive, then feed each result back in to recover the input
        for (int v = 0; v < 16; v++) begin
            drive(4'(v), 4'(v), ref_inv(4'(v)));
            tick();
        end
        bus.in_valid = 1'b0;
        tick(); tick();
        check("exh_drain", 32'(sb.size()), 32'd0);
        for (int v = 0; v < 16; v++) begin
            drive(outs_by_tag[v], 4'(v), 4'(v));
            tick();
        end
        bus.in_valid = 1'b0;
        tick(); tick();
        check("dbl_drain", 32'(sb.size()), 32'd0);

        // Backpressure
        bus.out_ready = 1'b0;
        sent = 0;
        for (int i = 0; i < 4; i++) begin
            drive(bp[sent], 4'(sent + 8), ref_inv(bp[sent]));
            tick();
            if (acc) sent++;
        end
        check("bp_accepted", 32'(sent), 32'd2);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_first", 32'(bus.out_data), 32'(ref_inv(bp[0])));
        bus.out_ready = 1'b1;
        cyc = 0;
        while ((sent < 4 || sb.size() != 0) && cyc < 20) begin
            if (sent < 4) drive(bp[sent], 4'(sent + 8), ref_inv(bp[sent]));
            else bus.in_valid = 1'b0;
            tick();
            if (acc) sent++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("bp_sent", 32'(sent), 32'd4);
        check("bp_drain", 32'(sb.size()), 32'd0);

        // Reset with both stages full; an input during reset is ignored
        bus.out_ready = 1'b0;
        drive(4'h5, 4'd1, ref_inv(4'h5)); tick();
        drive(4'hA, 4'd2, ref_inv(4'hA)); tick();
        check("mid_full", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        drive(4'h4, 4'd3, ref_inv(4'h4));
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        check("mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_out_data", 32'(bus.out_data), 32'h0);
        check("mid_out_tag", 32'(bus.out_tag), 32'h0);
        check("mid_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Random valid/ready traffic
        sent = 0;
        cyc = 0;
        while ((sent < 1000 || sb.size() != 0) && cyc < 20000) begin
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                logic [3:0] d;
                d = 4'($urandom_range(0, 15));
                drive(d, 4'($urandom_range(0, 15)), ref_inv(d));
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (acc) sent++;
            cyc++;
        end
        check("rand_sent", 32'(sent), 32'd1000);
        check("rand_drain", 32'(sb.size()), 32'd0);
`ifdef GF_INV_4_CHECK_EN
        check("err_clear", 32'(err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gf_inv_4_pipe.md
Name: gf_inv_4_pipe

Overview:
- Two-stage pipelined GF(2^4) inverter with valid/ready handshakes on input and output.
- Sits in the tower-field S-box datapath directly downstream of the GF(2^2) scale-by-Omega stage. It consumes 4-bit tower-field elements and returns their multiplicative inverses.
- A per-element sideband tag travels alongside each element so callers can match results to requests.

Parameters:
TAG_W, 4, width of the sideband tag carried alongside each element (>=1).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_data/in_tag valid
in_ready  output  1  block accepts input this cycle
in_data  input  4  element {a,b}: a=in_data[3:2], b=in_data[1:0]
in_tag  input  TAG_W  sideband, returned unchanged with result
out_valid  output  1  out_data/out_tag valid
out_ready  input  1  consumer accepts output this cycle
out_data  output  4  inverse of the accepted in_data
out_tag  output  TAG_W  tag of the accepted element

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- GF(2^2) arithmetic, normal basis [Omega^2, Omega]. x={x1,x0}; 1 = 2'b11.
  - mul(x,y): e=(x1^x0)&(y1^y0); result {(x1&y1)^e, (x0&y0)^e}.
  - sq(x) = inv(x) = {x0,x1}.
  - sclw(x) = {x1^x0, x1}.
- GF(2^4) over GF(2^2), normal basis [Z^4, Z], Z^2+Z+Omega=0.
  - c = sclw(sq(a^b)) ^ mul(a,b); d = inv(c).
  - out = {mul(d,b), mul(d,a)}.
  - Input 0 maps to 0. No special casing; this falls out of the formula.
- Stage 1 register (s1): holds a, b, c, tag and s1_valid.
- Stage 2 register (s2): holds out_data, out_tag and out_valid = s2_valid.
- Advance rules, evaluated combinationally:
  - s2_take = !s2_valid | out_ready.
  - s1_take = !s1_valid | s2_take.
  - in_ready = s1_take.
- Transfers:
  - in_valid & in_ready loads s1 and sets s1_valid.
  - s1_take & !in_valid clears s1_valid.
  - s2_take loads s2 from s1 and sets s2_valid = s1_valid.
- Latency and throughput:
  - Latency is exactly 2 cycles from input handshake to out_valid when out_ready is held high.
  - Throughput is 1 element/cycle.
  - Order is preserved; no element is dropped or duplicated.
- Backpressure:
  - With out_ready=0 and both stages full, in_ready=0 in the same cycle.
  - With one bubble present, in_ready stays 1 until it is filled.
  - The path out_ready -> in_ready is combinational; no other combinational in->out path exists.
- Output stability: out_data and out_tag hold stable while out_valid=1 and out_ready=0.
- Simultaneous events: acceptance at the input in the same cycle as output drain is legal and required at full rate.
- Reset:
  - rst=1 clears s1_valid and s2_valid, and forces out_data=0 and out_tag=0.
  - in_ready=1 in the cycle after reset deasserts; it is combinational from the cleared state.
  - Reset mid-stream discards all in-flight elements with no output.
  - An input handshake in a cycle with rst=1 is ignored.

Optional Feature:
- Macro: GF_INV_4_CHECK_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - On each output handshake, the block computes mul4(in-element, out_data) in GF(2^4) using the same basis, from a copy of {a,b} carried in s2.
  - err sets sticky when the product != 4'hF for a nonzero element, or when out_data != 0 for a zero element.
  - err is cleared only by rst.
- Not defined:
  - err port and the extra s2 storage are absent.
  - Datapath behaviour is otherwise identical.

Test Plan:
- Single transfer: after reset, in_data=4'hC, tag=1, out_ready=1 -> 2 cycles later out_valid=1, out_data=4'h2, out_tag=1.
- Known inverses, back-to-back with out_ready=1:
  - Inputs 4'h0, 4'hF, 4'h6, 4'hE.
  - Outputs on consecutive cycles 4'h0, 4'hF, 4'hE, 4'h6, with tags in order.
- Exhaustive: all 16 inputs -> each out_data times input equals 4'hF (0 -> 0). Inverting out_data again returns the original input.
- Backpressure:
  - Stream 4 elements with out_ready=0 -> in_ready drops after 2 accepted.
  - out_data holds the first result stable.
  - Raising out_ready drains all 4 in order with no loss.
- Reset mid-stream: rst=1 for 1 cycle with both stages full -> out_valid=0 and out_data=0 next cycle; no stale element later appears.
- Random valid/ready toggling, 1000 elements, scoreboard on data+tag -> zero mismatches. With GF_INV_4_CHECK_EN defined, err stays 0.
